// File: rtl/gzip_decompress_adapter.sv
// Purpose : splits host lines into core words (empty slices skipped) and packs core output words back into host lines.
// Latency : ingress 1 cycle line accept -> first core word; egress 1 cycle after the flushing word -> m_tvalid.
// Backpress: s_tready only while the line buffer is free or its final word is being taken; core_out_tready = !m_tvalid || m_tready.
//
// Ports: clk/rst_n (synchronous, active-low); s_* host compressed lines in; core_in_* words to the core;
//        core_out_* decompressed words from the core; m_* decompressed lines out.
// Optional: define GZIP_DECOMP_STATS_EN to add stat_in_bytes / stat_out_bytes / stat_members counters.
module gzip_decompress_adapter #(
    parameter int DATA_BITS = 512,
    parameter int CORE_BITS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [CORE_BITS-1:0]   core_in_tdata,
    output logic [CORE_BITS/8-1:0] core_in_tkeep,
    output logic                   core_in_tlast,
    output logic                   core_in_tvalid,
    input  logic                   core_in_tready,
    input  logic [CORE_BITS-1:0]   core_out_tdata,
    input  logic [CORE_BITS/8-1:0] core_out_tkeep,
    input  logic                   core_out_tlast,
    input  logic                   core_out_tvalid,
    output logic                   core_out_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
`ifdef GZIP_DECOMP_STATS_EN
    ,
    output logic [47:0]            stat_in_bytes,
    output logic [47:0]            stat_out_bytes,
    output logic [31:0]            stat_members
`endif
);

    localparam int WORDS = DATA_BITS / CORE_BITS;
    localparam int CK    = CORE_BITS / 8;
    localparam int DK    = DATA_BITS / 8;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Held low through reset and released one clock later, so neither
    // side handshakes while state is being cleared.
    logic ready_en;

    // ---------------- ingress: line buffer + slice index ----------------
    logic                 held;
    logic                 line_last;
    logic [DATA_BITS-1:0] line_dat;
    logic [DK-1:0]        line_keep;
    logic [IW-1:0]        idx;

    logic [WORDS-1:0]     in_ne;
    logic [WORDS-1:0]     line_ne;
    logic                 in_any;
    logic [IW-1:0]        in_first;
    logic                 has_above;
    logic [IW-1:0]        next_idx;

    // Downward scans: the last hit written is the lowest matching slice.
    always_comb begin
        in_ne     = '0;
        line_ne   = '0;
        in_any    = 1'b0;
        in_first  = '0;
        has_above = 1'b0;
        next_idx  = idx;
        for (int i = WORDS - 1; i >= 0; i--) begin
            in_ne[i]   = |s_tkeep[i*CK +: CK];
            line_ne[i] = |line_keep[i*CK +: CK];
            if (in_ne[i]) begin
                in_any   = 1'b1;
                in_first = IW'(i);
            end
            if (line_ne[i] && (IW'(i) > idx)) begin
                has_above = 1'b1;
                next_idx  = IW'(i);
            end
        end
    end

    logic in_acc;
    logic word_acc;

    assign core_in_tdata  = line_dat[idx*CORE_BITS +: CORE_BITS];
    assign core_in_tkeep  = line_keep[idx*CK +: CK];
    assign core_in_tlast  = held && line_last && !has_above;
    assign core_in_tvalid = held;
    // Accepting a new line while the final word leaves keeps lines bubble-free.
    assign s_tready       = ready_en && (!held || (!has_above && core_in_tready));
    assign in_acc         = s_tvalid && s_tready;
    assign word_acc       = held && core_in_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            held      <= 1'b0;
            line_last <= 1'b0;
            line_dat  <= '0;
            line_keep <= '0;
            idx       <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_acc) begin
                // An all-empty line still emits one word when it ends a member;
                // otherwise it is swallowed without occupying the buffer.
                held      <= in_any || s_tlast;
                line_dat  <= s_tdata;
                line_keep <= s_tkeep;
                line_last <= s_tlast;
                idx       <= in_first;
            end else if (word_acc) begin
                if (has_above) begin
                    idx <= next_idx;
                end else begin
                    held <= 1'b0;
                end
            end
        end
    end

    // ---------------- egress: slot packer + output line ----------------
    logic [IW-1:0]        cnt;
    logic [DATA_BITS-1:0] acc_dat;
    logic [DK-1:0]        acc_keep;
    logic [DATA_BITS-1:0] next_dat;
    logic [DK-1:0]        next_keep;
    logic                 out_acc;
    logic                 out_ne;
    logic                 out_drop;
    logic                 flush;

    assign core_out_tready = ready_en && (!m_tvalid || m_tready);
    assign out_acc         = core_out_tvalid && core_out_tready;
    assign out_ne          = |core_out_tkeep;
    assign out_drop        = !out_ne && !core_out_tlast;
    assign flush           = (cnt == IW'(WORDS - 1)) || core_out_tlast;

    // Slots above cnt stay zero because the accumulator is cleared on flush.
    // An empty tlast word closes the line without touching slot cnt.
    always_comb begin
        next_dat  = acc_dat;
        next_keep = acc_keep;
        if (out_ne) begin
            next_dat[cnt*CORE_BITS +: CORE_BITS] = core_out_tdata;
            next_keep[cnt*CK +: CK]              = core_out_tkeep;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_dat  <= '0;
            acc_keep <= '0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (out_acc && !out_drop) begin
                if (flush) begin
                    m_tdata  <= next_dat;
                    m_tkeep  <= next_keep;
                    m_tlast  <= core_out_tlast;
                    m_tvalid <= 1'b1;
                    cnt      <= '0;
                    acc_dat  <= '0;
                    acc_keep <= '0;
                end else begin
                    acc_dat  <= next_dat;
                    acc_keep <= next_keep;
                    cnt      <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef GZIP_DECOMP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_in_bytes  <= '0;
            stat_out_bytes <= '0;
            stat_members   <= '0;
        end else begin
            if (in_acc) begin
                stat_in_bytes <= stat_in_bytes + 48'($countones(s_tkeep));
            end
            if (out_acc) begin
                stat_out_bytes <= stat_out_bytes + 48'($countones(core_out_tkeep));
            end
            if (m_tvalid && m_tready && m_tlast) begin
                stat_members <= stat_members + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gzip_decompress_adapter.sv
// Purpose : loopback bench for gzip_decompress_adapter (core_in_* wired to core_out_* through a stall gate).
// Latency : expected words/lines come from a queue-based reference model filled when each line is driven.
// Backpress: core_in_tready gating and m_tready are driven by the bench, directed or random.
`timescale 1ns/1ps
module tb_gzip_decompress_adapter;
    localparam int DB = 512;
    localparam int CB = 64;
    localparam int W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [DB-1:0]   s_tdata;
    logic [DB/8-1:0] s_tkeep;
    logic            s_tlast, s_tvalid, s_tready;
    logic [CB-1:0]   core_in_tdata, core_out_tdata;
    logic [CB/8-1:0] core_in_tkeep, core_out_tkeep;
    logic            core_in_tlast, core_in_tvalid, core_in_tready;
    logic            core_out_tlast, core_out_tvalid, core_out_tready;
    logic [DB-1:0]   m_tdata;
    logic [DB/8-1:0] m_tkeep;
    logic            m_tlast, m_tvalid, m_tready;
`ifdef GZIP_DECOMP_STATS_EN
    logic [47:0]     stat_in_bytes, stat_out_bytes;
    logic [31:0]     stat_members;
`endif

    // stall gate and output-ready control
    logic gate_tgl = 1'b0, gate_bit = 1'b0;
    logic mrdy_rand = 1'b0, mrdy_bit = 1'b1, mrdy_val = 1'b1;
    logic core_gate;
    assign core_gate       = gate_tgl ? gate_bit : 1'b1;
    assign core_in_tready  = core_out_tready & core_gate;
    assign core_out_tvalid = core_in_tvalid & core_gate;
    assign core_out_tdata  = core_in_tdata;
    assign core_out_tkeep  = core_in_tkeep;
    assign core_out_tlast  = core_in_tlast;
    assign m_tready        = mrdy_rand ? mrdy_bit : mrdy_val;

    gzip_decompress_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .core_in_tdata(core_in_tdata), .core_in_tkeep(core_in_tkeep), .core_in_tlast(core_in_tlast),
        .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready),
        .core_out_tdata(core_out_tdata), .core_out_tkeep(core_out_tkeep), .core_out_tlast(core_out_tlast),
        .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef GZIP_DECOMP_STATS_EN
        ,
        .stat_in_bytes(stat_in_bytes), .stat_out_bytes(stat_out_bytes), .stat_members(stat_members)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {logic [CB-1:0] d; logic [7:0] k; logic l;} word_t;
    typedef struct packed {logic [DB-1:0] d; logic [63:0] k; logic l;} line_t;

    word_t         exp_w[$];
    line_t         exp_l[$];
    int            pk_n = 0;
    logic [DB-1:0] pk_d = '0;
    logic [63:0]   pk_k = '0;
    longint        mdl_in = 0, mdl_out = 0, mdl_mem = 0;

    function automatic void model_reset();
        exp_w.delete();
        exp_l.delete();
        pk_n = 0; pk_d = '0; pk_k = '0;
        mdl_in = 0; mdl_out = 0; mdl_mem = 0;
    endfunction

    // Pack words into slot order; empty non-last words vanish, a last word closes the line.
    function automatic void model_word(input word_t w);
        line_t ln;
        exp_w.push_back(w);
        mdl_out += $countones(w.k);
        if (w.k == 8'h0 && !w.l) return;
        if (w.k != 8'h0) begin
            pk_d[pk_n*CB +: CB] = w.d;
            pk_k[pk_n*8 +: 8]   = w.k;
        end
        if (pk_n == W - 1 || w.l) begin
            ln.d = pk_d; ln.k = pk_k; ln.l = w.l;
            exp_l.push_back(ln);
            if (w.l) mdl_mem++;
            pk_n = 0; pk_d = '0; pk_k = '0;
        end else begin
            pk_n++;
        end
    endfunction

    // A line becomes the list of its non-empty 8-byte slices in ascending order.
    function automatic void model_line(input logic [DB-1:0] d, input logic [63:0] k, input logic l);
        int    sl[$];
        word_t w;
        mdl_in += $countones(k);
        for (int i = 0; i < W; i++) if (k[i*8 +: 8] != 8'h0) sl.push_back(i);
        if (sl.size() == 0) begin
            if (l) begin
                w.d = d[CB-1:0]; w.k = 8'h0; w.l = 1'b1;
                model_word(w);
            end
        end else begin
            foreach (sl[j]) begin
                w.d = d[sl[j]*CB +: CB];
                w.k = k[sl[j]*8 +: 8];
                w.l = l && (j == sl.size() - 1);
                model_word(w);
            end
        end
    endfunction

    // ---------------- free-running helpers ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        gate_bit <= ~gate_bit;
        mrdy_bit <= 1'($urandom_range(0, 1));
    end

    // ---------------- monitors ----------------
    int              hs_cyc[$];
    logic            pend_in = 1'b0, pend_m = 1'b0;
    logic [72:0]     pend_in_val = '0;
    logic [DB+64:0]  pend_m_val = '0;
    logic [63:0]     last_m_keep = '0;
    logic            last_m_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_in) begin
                check("in_stall_vld", core_in_tvalid, 1);
                check("in_stall_dat", {core_in_tdata, core_in_tkeep, core_in_tlast}, pend_in_val);
            end
            if (pend_m) begin
                check("out_stall_vld", m_tvalid, 1);
                check("out_stall_dat", m_tdata, pend_m_val[DB+64:65]);
                check("out_stall_keep", {m_tkeep, m_tlast}, pend_m_val[64:0]);
            end
            if (m_tvalid && !m_tready) check("out_held_rdy", core_out_tready, 0);
            if (core_in_tvalid && core_in_tready) begin
                hs_cyc.push_back(cyc);
                check("in_word_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    check("in_word", {core_in_tdata, core_in_tkeep, core_in_tlast}, exp_w[0]);
                    void'(exp_w.pop_front());
                end
            end
            if (m_tvalid && m_tready) begin
                check("out_line_expected", exp_l.size() != 0, 1);
                if (exp_l.size() != 0) begin
                    check("out_dat", m_tdata, exp_l[0].d);
                    check("out_keep", m_tkeep, exp_l[0].k);
                    check("out_last", m_tlast, exp_l[0].l);
                    void'(exp_l.pop_front());
                end
                last_m_keep <= m_tkeep;
                last_m_last <= m_tlast;
            end
            pend_in     <= core_in_tvalid && !core_in_tready;
            pend_in_val <= {core_in_tdata, core_in_tkeep, core_in_tlast};
            pend_m      <= m_tvalid && !m_tready;
            pend_m_val  <= {m_tdata, m_tkeep, m_tlast};
        end else begin
            pend_in <= 1'b0;
            pend_m  <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DB-1:0] rnd_data();
        logic [DB-1:0] r;
        for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rnd_keep();
        logic [63:0] k;
        for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 3))
                0:       k[i*8 +: 8] = 8'h00;
                3:       k[i*8 +: 8] = 8'($urandom_range(1, 255));
                default: k[i*8 +: 8] = 8'hFF;
            endcase
        end
        return k;
    endfunction

    task automatic send_line(input logic [DB-1:0] d, input logic [63:0] k, input logic l);
        int n = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        model_line(d, k, l);
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 2000);
        check("s_accept", s_tready, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_w.size() != 0 || exp_l.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_words", exp_w.size(), 0);
        check("drain_lines", exp_l.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_core_in_tvalid", core_in_tvalid, 0);
        check("rst_core_out_tready", core_out_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
`ifdef GZIP_DECOMP_STATS_EN
        check("rst_stat_in", stat_in_bytes, 0);
        check("rst_stat_out", stat_out_bytes, 0);
        check("rst_stat_mem", stat_members, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_tready", s_tready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DB-1:0] d;
        rst_n = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // two identical full lines, second ends the member: 16 words in consecutive cycles
        hs_cyc.delete();
        d = rnd_data();
        send_line(d, '1, 1'b0);
        send_line(d, '1, 1'b1);
        drain();
        check("b2b_words", hs_cyc.size(), 16);
        if (hs_cyc.size() == 16) check("b2b_span", hs_cyc[15] - hs_cyc[0], 15);

        // sparse line: two populated slices pack into slots 0-1
        hs_cyc.delete();
        send_line(rnd_data(), 64'h00FF_0000_0000_00FF, 1'b1);
        drain();
        check("sparse_words", hs_cyc.size(), 2);
        check("sparse_keep", last_m_keep, 64'hFFFF);
        check("sparse_last", last_m_last, 1);

        // empty non-last line is swallowed, the following full line gives 8 words
        hs_cyc.delete();
        send_line(rnd_data(), 64'h0, 1'b0);
        send_line(rnd_data(), '1, 1'b0);
        drain();
        check("empty_skip_words", hs_cyc.size(), 8);

        // core stalls every other cycle with random sink backpressure
        gate_tgl = 1'b1;
        mrdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) send_line(rnd_data(), rnd_keep(), i == 5);
        drain();
        gate_tgl = 1'b0;
        mrdy_rand = 1'b0;

        // sink held off for 20 cycles with a full line in flight
        mrdy_val = 1'b0;
        send_line(rnd_data(), '1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("sink_stall_vld", m_tvalid, 1);
        check("sink_stall_rdy", core_out_tready, 0);
        mrdy_val = 1'b1;
        drain();

        // three words then an empty last word
        send_line(rnd_data(), 64'h0000_0000_00FF_FFFF, 1'b0);
        send_line(rnd_data(), 64'h0, 1'b1);
        drain();
        check("partial_keep", last_m_keep, 64'hFF_FFFF);
        check("partial_last", last_m_last, 1);

        // empty last word with nothing packed yields an empty last line
        send_line(rnd_data(), 64'h0, 1'b1);
        drain();
        check("empty_last_keep", last_m_keep, 64'h0);
        check("empty_last_last", last_m_last, 1);

        // random traffic under both kinds of backpressure
        gate_tgl = 1'b1;
        mrdy_rand = 1'b1;
        for (int i = 0; i < 24; i++) send_line(rnd_data(), rnd_keep(), (i == 23) || ($urandom_range(0, 3) == 0));
        drain();
        gate_tgl = 1'b0;
        mrdy_rand = 1'b0;

        // 130-byte member from a clean reset
        do_reset();
        send_line(rnd_data(), '1, 1'b0);
        send_line(rnd_data(), '1, 1'b0);
        send_line(rnd_data(), 64'h3, 1'b1);
        drain();
`ifdef GZIP_DECOMP_STATS_EN
        check("stat_in_130", stat_in_bytes, 130);
        check("stat_in_model", stat_in_bytes, mdl_in);
        check("stat_out_model", stat_out_bytes, mdl_out);
        check("stat_members", stat_members, 1);
`endif

        // reset in the middle of a line, then a clean member
        s_tdata = rnd_data(); s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
        model_line(s_tdata, s_tkeep, s_tlast);
        for (int n = 0; n < 50 && !s_tready; n++) @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        send_line(rnd_data(), '1, 1'b1);
        drain();
        check("after_rst_last", last_m_last, 1);
        check("after_rst_keep", last_m_keep, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
